// File: rtl/imuldiv_muldiv_arbiter.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_arbiter
//
// Shares one in-order multiply/divide unit between two requesters.
// Requests are granted round-robin. The id of each issued request is pushed
// into a small owner FIFO so that responses, which return in issue order,
// can be steered back to the requester that asked for them. Both paths are
// purely combinational forwarding. The only state is the priority bit and
// the owner FIFO.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   req0_* / req1_*        : requester op (fn, a, b) with val/rdy handshake
//   resp0_* / resp1_*      : 64-bit result back to each requester, val/rdy
//   muldivreq_*            : granted op forwarded to the shared unit
//   muldivresp_*           : result from the shared unit, val/rdy
//
// fn encoding: 0 mul, 1 div, 2 divu, 3 rem, 4 remu.
// ---------------------------------------------------------------------------
module imuldiv_muldiv_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [2:0]          req0_msg_fn,
    input  logic [DATA_W-1:0]   req0_msg_a,
    input  logic [DATA_W-1:0]   req0_msg_b,
    input  logic                req0_val,
    output logic                req0_rdy,
    output logic [2*DATA_W-1:0] resp0_msg_result,
    output logic                resp0_val,
    input  logic                resp0_rdy,

    input  logic [2:0]          req1_msg_fn,
    input  logic [DATA_W-1:0]   req1_msg_a,
    input  logic [DATA_W-1:0]   req1_msg_b,
    input  logic                req1_val,
    output logic                req1_rdy,
    output logic [2*DATA_W-1:0] resp1_msg_result,
    output logic                resp1_val,
    input  logic                resp1_rdy,

    output logic [2:0]          muldivreq_msg_fn,
    output logic [DATA_W-1:0]   muldivreq_msg_a,
    output logic [DATA_W-1:0]   muldivreq_msg_b,
    output logic                muldivreq_val,
    input  logic                muldivreq_rdy,

    input  logic [2*DATA_W-1:0] muldivresp_msg_result,
    input  logic                muldivresp_val,
    output logic                muldivresp_rdy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic             prio;
    logic [DEPTH-1:0] owner_q;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic not_full;
    logic not_empty;
    logic any_val;
    logic grant;
    logic owner;
    logic req_fire;
    logic resp_fire;

    // Fullness comes from the registered count only. A pop in the same cycle
    // does not open a slot until the next cycle, which keeps the ready path
    // free of any dependency on the response side.
    assign not_full  = (count < FULL_CNT);
    assign not_empty = (count != '0);
    assign any_val   = req0_val || req1_val;

    // Port 0 when it alone is valid (and when nothing is valid, so the
    // forwarded fields default to port 0). Ties are broken by prio.
    assign grant = (req0_val && req1_val) ? prio : req1_val;

    assign muldivreq_val    = any_val && not_full;
    assign muldivreq_msg_fn = grant ? req1_msg_fn : req0_msg_fn;
    assign muldivreq_msg_a  = grant ? req1_msg_a  : req0_msg_a;
    assign muldivreq_msg_b  = grant ? req1_msg_b  : req0_msg_b;

    assign req0_rdy = muldivreq_rdy && not_full && any_val && !grant;
    assign req1_rdy = muldivreq_rdy && not_full && any_val &&  grant;

    // The unit answers in order, so the FIFO head always owns the response
    // currently offered. A stalled owner therefore blocks the other port.
    assign owner = owner_q[head];

    assign resp0_msg_result = muldivresp_msg_result;
    assign resp1_msg_result = muldivresp_msg_result;
    assign resp0_val        = muldivresp_val && not_empty && !owner;
    assign resp1_val        = muldivresp_val && not_empty &&  owner;
    assign muldivresp_rdy   = not_empty && (owner ? resp1_rdy : resp0_rdy);

    assign req_fire  = muldivreq_val && muldivreq_rdy;
    assign resp_fire = muldivresp_val && muldivresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio  <= 1'b0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (req_fire) begin
                prio <= ~grant;
                tail <= tail + 1'b1;
            end
            if (resp_fire) begin
                head <= head + 1'b1;
            end
            case ({req_fire, resp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Owner storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            owner_q[tail] <= grant;
        end
    end

endmodule

// File: tb/tb_imuldiv_muldiv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imuldiv_muldiv_arbiter
//
// Bench for the two-port muldiv arbiter. A behavioural in-order muldiv unit
// (one-cycle latency, unbounded queue) sits behind the arbiter. Expected
// results are queued per port when a request is driven; the monitor collects
// what each port actually receives, and each test task compares the two.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imuldiv_muldiv_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [2:0]  req0_msg_fn = '0;
    logic [31:0] req0_msg_a = '0;
    logic [31:0] req0_msg_b = '0;
    logic        req0_val = 1'b0;
    logic        req0_rdy;
    logic [63:0] resp0_msg_result;
    logic        resp0_val;
    logic        resp0_rdy = 1'b1;
    logic [2:0]  req1_msg_fn = '0;
    logic [31:0] req1_msg_a = '0;
    logic [31:0] req1_msg_b = '0;
    logic        req1_val = 1'b0;
    logic        req1_rdy;
    logic [63:0] resp1_msg_result;
    logic        resp1_val;
    logic        resp1_rdy = 1'b1;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a;
    logic [31:0] muldivreq_msg_b;
    logic        muldivreq_val;
    logic        muldivreq_rdy = 1'b1;
    logic [63:0] muldivresp_msg_result = '0;
    logic        muldivresp_val = 1'b0;
    logic        muldivresp_rdy;

    int total = 0;
    int bad   = 0;

    stim_t       stim0[$];
    stim_t       stim1[$];
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    logic [63:0] got0[$];
    logic [63:0] got1[$];
    logic        issue_log[$];
    logic        resp_log[$];
    logic        seen0 = 1'b0;
    logic        seen1 = 1'b0;
    int          both_cnt = 0;

    imuldiv_muldiv_arbiter #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req0_msg_fn           (req0_msg_fn),
        .req0_msg_a            (req0_msg_a),
        .req0_msg_b            (req0_msg_b),
        .req0_val              (req0_val),
        .req0_rdy              (req0_rdy),
        .resp0_msg_result      (resp0_msg_result),
        .resp0_val             (resp0_val),
        .resp0_rdy             (resp0_rdy),
        .req1_msg_fn           (req1_msg_fn),
        .req1_msg_a            (req1_msg_a),
        .req1_msg_b            (req1_msg_b),
        .req1_val              (req1_val),
        .req1_rdy              (req1_rdy),
        .resp1_msg_result      (resp1_msg_result),
        .resp1_val             (resp1_val),
        .resp1_rdy             (resp1_rdy),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy)
    );

    // Reference muldiv: signed 64-bit product, or {remainder, quotient}.
    function automatic logic [63:0] golden(input logic [2:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [31:0]        uq;
        logic [31:0]        ur;
        golden = '0;
        case (fn)
            3'd0: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                golden = p;
            end
            3'd1, 3'd3: begin
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                golden = {sr, sq};
            end
            3'd2, 3'd4: begin
                uq = a / b;
                ur = a % b;
                golden = {ur, uq};
            end
            default: golden = '0;
        endcase
    endfunction

    function automatic stim_t mk(input logic [2:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] e);
        stim_t s;
        s.fn = fn;
        s.a = a;
        s.b = b;
        s.exp = e;
        return s;
    endfunction

    // Shared unit model plus response monitor.
    logic [63:0] unit_q[$];
    logic        s_reset;
    logic        s_req_fire;
    logic        s_resp_fire;
    logic [63:0] s_req_res;

    always begin
        @(negedge clk);
        s_reset     = reset;
        s_req_fire  = muldivreq_val && muldivreq_rdy;
        s_resp_fire = muldivresp_val && muldivresp_rdy;
        s_req_res   = golden(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b);
        if (!s_reset) begin
            if (s_req_fire) issue_log.push_back(req1_val && req1_rdy);
            if (resp0_val && resp0_rdy) begin
                got0.push_back(resp0_msg_result);
                resp_log.push_back(1'b0);
            end
            if (resp1_val && resp1_rdy) begin
                got1.push_back(resp1_msg_result);
                resp_log.push_back(1'b1);
            end
            if (resp0_val) seen0 = 1'b1;
            if (resp1_val) seen1 = 1'b1;
            if (resp0_val && resp1_val) both_cnt++;
        end
        @(posedge clk);
        #1;
        if (s_reset) begin
            unit_q.delete();
        end else begin
            if (s_resp_fire && unit_q.size() > 0) unit_q.delete(0);
            if (s_req_fire) unit_q.push_back(s_req_res);
        end
        if (unit_q.size() > 0) begin
            muldivresp_val        = 1'b1;
            muldivresp_msg_result = unit_q[0];
        end else begin
            muldivresp_val        = 1'b0;
            muldivresp_msg_result = '0;
        end
    end

    task automatic set_req(input int port, input logic v, input stim_t s);
        if (port == 0) begin
            req0_val = v; req0_msg_fn = s.fn; req0_msg_a = s.a; req0_msg_b = s.b;
        end else begin
            req1_val = v; req1_msg_fn = s.fn; req1_msg_a = s.a; req1_msg_b = s.b;
        end
    endtask

    // Issues n queued requests on one port, holding each until accepted.
    task automatic drive_port(input int port, input int n, output int timeouts);
        stim_t s;
        logic  fired;
        timeouts = 0;
        for (int i = 0; i < n; i++) begin
            if (port == 0) begin
                s = stim0.pop_front();
                exp0.push_back(s.exp);
            end else begin
                s = stim1.pop_front();
                exp1.push_back(s.exp);
            end
            set_req(port, 1'b1, s);
            fired = 1'b0;
            for (int c = 0; c < 200 && !fired; c++) begin
                @(negedge clk);
                fired = (port == 0) ? req0_rdy : req1_rdy;
                @(posedge clk);
                #1;
            end
            if (!fired) timeouts++;
        end
        s = '0;
        set_req(port, 1'b0, s);
    endtask

    task automatic wait_drain(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(posedge clk);
            ok = (got0.size() == exp0.size()) && (got1.size() == exp1.size());
        end
        #1;
    endtask

    task automatic clear_logs();
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
        issue_log.delete(); resp_log.delete();
        seen0 = 1'b0; seen1 = 1'b0; both_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (req0_rdy !== 1'b0) begin bad++; $display("FAIL reset_req0_rdy got=%b want=0", req0_rdy); end
        total++; if (req1_rdy !== 1'b0) begin bad++; $display("FAIL reset_req1_rdy got=%b want=0", req1_rdy); end
        total++; if (resp0_val !== 1'b0) begin bad++; $display("FAIL reset_resp0_val got=%b want=0", resp0_val); end
        total++; if (resp1_val !== 1'b0) begin bad++; $display("FAIL reset_resp1_val got=%b want=0", resp1_val); end
        total++; if (muldivresp_rdy !== 1'b0) begin bad++; $display("FAIL reset_muldivresp_rdy got=%b want=0", muldivresp_rdy); end
        total++; if (muldivreq_val !== 1'b0) begin bad++; $display("FAIL reset_muldivreq_val got=%b want=0", muldivreq_val); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_port0_only();
        int          to;
        logic        ok;
        logic [63:0] e;
        logic [63:0] g;
        clear_logs();
        stim0.push_back(mk(3'd0, 32'h0000_0008, 32'h0000_0003, 64'h0000_0000_0000_0018));
        drive_port(0, 1, to);
        total++; if (to !== 0) begin bad++; $display("FAIL p0only_issue timeouts=%0d want=0", to); end
        wait_drain(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL p0only_drain got0=%0d got1=%0d want=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            g = 'x;
            if (got0.size() > 0) g = got0.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL p0only_result got=%h want=%h", g, e); end
        end
        total++; if (seen1 !== 1'b0) begin bad++; $display("FAIL p0only_resp1_val got=%b want=0", seen1); end
    endtask

    task automatic test_port1_only();
        int          to;
        logic        ok;
        logic [63:0] e;
        logic [63:0] g;
        clear_logs();
        stim1.push_back(mk(3'd1, 32'h0000_0222, 32'h0000_002a, 64'h0000_0000_0000_000d));
        drive_port(1, 1, to);
        total++; if (to !== 0) begin bad++; $display("FAIL p1only_issue timeouts=%0d want=0", to); end
        wait_drain(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL p1only_drain got0=%0d got1=%0d want=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            g = 'x;
            if (got1.size() > 0) g = got1.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL p1only_result got=%h want=%h", g, e); end
        end
        total++; if (seen0 !== 1'b0) begin bad++; $display("FAIL p1only_resp0_val got=%b want=0", seen0); end
    endtask

    // Both ports valid on the first cycle out of reset, then a second pair
    // to show the priority returned to port 0.
    task automatic test_both_after_reset();
        int          to0;
        int          to1;
        logic        ok;
        logic [63:0] e;
        logic [63:0] g;
        logic [3:0]  want_order;
        logic        v;
        want_order = 4'b1010;
        do_reset();
        clear_logs();
        stim0.push_back(mk(3'd0, 32'hffff_fff8, 32'h0000_0008, 64'hffff_ffff_ffff_ffc0));
        stim1.push_back(mk(3'd4, 32'h0000_0222, 32'h0000_0032, 64'h0000_002e_0000_000a));
        fork
            drive_port(0, 1, to0);
            drive_port(1, 1, to1);
        join
        wait_drain(ok);
        stim0.push_back(mk(3'd2, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000e));
        stim1.push_back(mk(3'd0, 32'hffff_ffff, 32'hffff_ffff, 64'h0000_0000_0000_0001));
        fork
            drive_port(0, 1, to0);
            drive_port(1, 1, to1);
        join
        wait_drain(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL both_drain got0=%0d got1=%0d want=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
        for (int i = 0; i < 4; i++) begin
            v = 1'bx;
            if (i < issue_log.size()) v = issue_log[i];
            total++; if (v !== want_order[i]) begin bad++; $display("FAIL both_issue_order idx=%0d got=%b want=%b", i, v, want_order[i]); end
            v = 1'bx;
            if (i < resp_log.size()) v = resp_log[i];
            total++; if (v !== want_order[i]) begin bad++; $display("FAIL both_resp_order idx=%0d got=%b want=%b", i, v, want_order[i]); end
        end
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            g = 'x;
            if (got0.size() > 0) g = got0.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL both_result0 got=%h want=%h", g, e); end
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            g = 'x;
            if (got1.size() > 0) g = got1.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL both_result1 got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        int          to0;
        int          to1;
        logic        ok;
        logic [63:0] e;
        logic [63:0] g;
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            fn = 3'($urandom_range(0, 4)); a = $urandom; b = $urandom | 32'h1;
            if (b == 32'hffff_ffff) b = 32'h7;
            stim0.push_back(mk(fn, a, b, golden(fn, a, b)));
            fn = 3'($urandom_range(0, 4)); a = $urandom; b = $urandom | 32'h1;
            if (b == 32'hffff_ffff) b = 32'h7;
            stim1.push_back(mk(fn, a, b, golden(fn, a, b)));
        end
        fork
            drive_port(0, 8, to0);
            drive_port(1, 8, to1);
        join
        wait_drain(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_drain got0=%0d got1=%0d want=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
        total++; if (issue_log.size() != 16) begin bad++; $display("FAIL b2b_issue_count got=%0d want=16", issue_log.size()); end
        for (int i = 0; i < issue_log.size(); i++) begin
            total++;
            if (issue_log[i] !== i[0]) begin bad++; $display("FAIL b2b_alternate idx=%0d got=%b want=%b", i, issue_log[i], i[0]); end
        end
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            g = 'x;
            if (got0.size() > 0) g = got0.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL b2b_result0 got=%h want=%h", g, e); end
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            g = 'x;
            if (got1.size() > 0) g = got1.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL b2b_result1 got=%h want=%h", g, e); end
        end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL b2b_dual_resp_val got=%0d want=0", both_cnt); end
    endtask

    // Fill the owner FIFO with port-0 work while port 0 refuses responses.
    task automatic test_full_stall();
        int          to;
        logic        ok;
        logic        fired;
        logic [63:0] e;
        logic [63:0] g;
        logic [3:0]  want_resp;
        logic        v;
        stim_t       s;
        want_resp = 4'b0100;
        clear_logs();
        resp0_rdy = 1'b0;
        stim0.push_back(mk(3'd0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000f));
        stim0.push_back(mk(3'd3, 32'hffff_fff9, 32'h0000_0002, 64'hffff_ffff_ffff_fffd));
        drive_port(0, 2, to);
        total++; if (to !== 0) begin bad++; $display("FAIL full_fill timeouts=%0d want=0", to); end
        s = mk(3'd0, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002a);
        exp0.push_back(s.exp);
        set_req(0, 1'b1, s);
        s = mk(3'd2, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000e);
        exp1.push_back(s.exp);
        set_req(1, 1'b1, s);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (req0_rdy !== 1'b0) begin bad++; $display("FAIL full_req0_rdy cyc=%0d got=%b want=0", c, req0_rdy); end
            total++; if (req1_rdy !== 1'b0) begin bad++; $display("FAIL full_req1_rdy cyc=%0d got=%b want=0", c, req1_rdy); end
            total++; if (muldivreq_val !== 1'b0) begin bad++; $display("FAIL full_muldivreq_val cyc=%0d got=%b want=0", c, muldivreq_val); end
            total++; if (muldivresp_rdy !== 1'b0) begin bad++; $display("FAIL full_muldivresp_rdy cyc=%0d got=%b want=0", c, muldivresp_rdy); end
            total++; if (resp0_val !== 1'b1) begin bad++; $display("FAIL full_resp0_val cyc=%0d got=%b want=1", c, resp0_val); end
            @(posedge clk);
            #1;
        end
        resp0_rdy = 1'b1;
        @(negedge clk);
        total++; if (muldivreq_val !== 1'b0) begin bad++; $display("FAIL nobypass_muldivreq_val got=%b want=0", muldivreq_val); end
        total++; if (req1_rdy !== 1'b0) begin bad++; $display("FAIL nobypass_req1_rdy got=%b want=0", req1_rdy); end
        total++; if (muldivresp_rdy !== 1'b1) begin bad++; $display("FAIL nobypass_muldivresp_rdy got=%b want=1", muldivresp_rdy); end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (muldivreq_val !== 1'b1) begin bad++; $display("FAIL freed_muldivreq_val got=%b want=1", muldivreq_val); end
        total++; if (req1_rdy !== 1'b1) begin bad++; $display("FAIL freed_req1_rdy got=%b want=1", req1_rdy); end
        total++; if (req0_rdy !== 1'b0) begin bad++; $display("FAIL freed_req0_rdy got=%b want=0", req0_rdy); end
        @(posedge clk);
        #1;
        s = '0;
        set_req(1, 1'b0, s);
        fired = 1'b0;
        for (int c = 0; c < 50 && !fired; c++) begin
            @(negedge clk);
            fired = req0_rdy;
            @(posedge clk);
            #1;
        end
        set_req(0, 1'b0, s);
        total++; if (fired !== 1'b1) begin bad++; $display("FAIL full_third_issue got=%b want=1", fired); end
        wait_drain(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL full_drain got0=%0d got1=%0d want=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
        for (int i = 0; i < 4; i++) begin
            v = 1'bx;
            if (i < resp_log.size()) v = resp_log[i];
            total++; if (v !== want_resp[i]) begin bad++; $display("FAIL full_resp_order idx=%0d got=%b want=%b", i, v, want_resp[i]); end
        end
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            g = 'x;
            if (got0.size() > 0) g = got0.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL full_result0 got=%h want=%h", g, e); end
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            g = 'x;
            if (got1.size() > 0) g = got1.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL full_result1 got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_reset_midflight();
        int          to;
        logic        ok;
        logic [63:0] e;
        logic [63:0] g;
        clear_logs();
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        stim0.push_back(mk(3'd0, 32'h0000_0011, 32'h0000_0002, 64'h0000_0000_0000_0022));
        stim1.push_back(mk(3'd1, 32'h0000_0064, 32'h0000_0005, 64'h0000_0000_0000_0014));
        drive_port(0, 1, to);
        drive_port(1, 1, to);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        @(negedge clk);
        total++; if (resp0_val !== 1'b0) begin bad++; $display("FAIL midrst_resp0_val got=%b want=0", resp0_val); end
        total++; if (resp1_val !== 1'b0) begin bad++; $display("FAIL midrst_resp1_val got=%b want=0", resp1_val); end
        total++; if (muldivresp_rdy !== 1'b0) begin bad++; $display("FAIL midrst_muldivresp_rdy got=%b want=0", muldivresp_rdy); end
        total++; if (muldivreq_val !== 1'b0) begin bad++; $display("FAIL midrst_muldivreq_val got=%b want=0", muldivreq_val); end
        @(posedge clk);
        #1;
        stim1.push_back(mk(3'd4, 32'h0000_0222, 32'h0000_0032, 64'h0000_002e_0000_000a));
        drive_port(1, 1, to);
        total++; if (to !== 0) begin bad++; $display("FAIL midrst_issue timeouts=%0d want=0", to); end
        wait_drain(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_drain got0=%0d got1=%0d want=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            g = 'x;
            if (got1.size() > 0) g = got1.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL midrst_result1 got=%h want=%h", g, e); end
        end
        total++; if (seen0 !== 1'b0) begin bad++; $display("FAIL midrst_resp0_residual got=%b want=0", seen0); end
    endtask

    initial begin
        test_reset();
        test_port0_only();
        test_both_after_reset();
        test_port1_only();
        test_back_to_back();
        test_full_stall();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imuldiv_muldiv_arbiter.md
IMULDIV_MULDIV_ARBITER -- requirements
Module: imuldiv_muldiv_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 2, max in-flight requests tracked in the owner FIFO (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_msg_fn  input  3, req0_msg_a  input  32, req0_msg_b  input  32  -- requester 0 op (fn encoding 0 mul, 1 div, 2 divu, 3 rem, 4 remu).
REQ-005 SHALL have ports: req0_val  input  1, req0_rdy  output  1  -- requester 0 val/rdy handshake.
REQ-006 SHALL have ports: resp0_msg_result  output  64, resp0_val  output  1, resp0_rdy  input  1  -- requester 0 response.
REQ-007 SHALL have ports req1_* and resp1_* identical to REQ-004..006 for requester 1.
REQ-008 SHALL have ports: muldivreq_msg_fn  output  3, muldivreq_msg_a  output  32, muldivreq_msg_b  output  32, muldivreq_val  output  1, muldivreq_rdy  input  1  -- to shared muldiv unit.
REQ-009 SHALL have ports: muldivresp_msg_result  input  64, muldivresp_val  input  1, muldivresp_rdy  output  1  -- from shared muldiv unit.

Function
REQ-010 SHALL treat a transfer as fired when val && rdy are both high on a rising edge; no transfer otherwise.
REQ-011 SHALL hold a 1-bit round-robin priority register prio (0 = port 0 favoured).
REQ-012 SHALL hold an owner FIFO of DEPTH 1-bit entries, count register 0..DEPTH, head/tail pointers wrapping modulo DEPTH.
REQ-013 SHALL grant combinationally: only one valid -> that port; both valid -> port prio; none -> no grant.
REQ-014 SHALL drive muldivreq_val = (req0_val || req1_val) && (count < DEPTH); msg fields = granted port's fields (port 0 fields when no grant).
REQ-015 SHALL drive reqN_rdy = muldivreq_rdy && (count < DEPTH) && grant==N; non-granted port rdy = 0.
REQ-016 SHALL, on request fire, push the granted port id at tail and set prio to the other port; prio unchanged when no fire.
REQ-017 SHALL route responses in issue order (unit is in-order): owner = FIFO head; resp<owner>_val = muldivresp_val && count>0; other resp_val = 0; both resp_msg_result = muldivresp_msg_result.
REQ-018 SHALL drive muldivresp_rdy = (count>0) && resp<owner>_rdy; 0 when FIFO empty.
REQ-019 SHALL pop head on response fire.
REQ-020 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-021 SHALL, when full (count==DEPTH), deassert both reqN_rdy and muldivreq_val even if a pop fires that cycle (no bypass; registered count only).
REQ-022 SHALL impose head-of-line ordering: a stalled owner response blocks later responses of the other port.
REQ-023 SHALL add zero cycles of latency on request and response paths (pure combinational forwarding, state only in prio/FIFO).
REQ-024 SHALL never drop or duplicate a request or response; muldivresp_val with empty FIFO is a protocol error and is not accepted.

Reset
REQ-025 SHALL, while reset high at a rising edge, set prio=0, count=0, head=tail=0, discarding in-flight ownership (the shared unit shares this reset).
REQ-026 SHALL, after reset, present req0_rdy=req1_rdy=0 unless val asserted, resp0_val=resp1_val=0, muldivresp_rdy=0, muldivreq_val=0 with no valids.
REQ-027 SHALL apply reset asserted mid-transaction identically to REQ-025 with no residual response to either port.

Verification
REQ-028 SHALL test: port 0 only, mul a=0x00000008 b=0x00000003 -> resp0 result 0x00000000_00000018, resp1_val never high.
REQ-029 SHALL test: port 1 only, div a=0x00000222 b=0x0000002a -> resp1 result 0x00000000_0000000d, resp0_val never high.
REQ-030 SHALL test: both valid in first cycle after reset (port0 mul 0xfffffff8*0x8, port1 remu 0x00000222/0x32) -> port 0 issued first, resp0 0xffffffff_ffffffc0 then resp1 0x0000002e_0000000a; prio ends at 0.
REQ-031 SHALL test: both ports continuously valid for 8 requests each, sinks always ready -> issues strictly alternate 0,1,0,1..., all results match golden model per port.
REQ-032 SHALL test: DEPTH=2, resp0_rdy held low after two port-0 issues -> req0_rdy=req1_rdy=0 and muldivreq_val=0 until resp0_rdy rises, then exactly one slot frees per pop.
REQ-033 SHALL test: reset asserted with 2 requests in flight -> next cycle count=0, no resp_val, new port-1 request completes correctly.
